// File: rtl/i2c_reg_bridge.sv
// I2C target front end driving a single-cycle 8-bit register bus (open-drain SDA via sda_oe).
// Optional burst pointer auto-increment: define I2C_AUTOINC_EN.
module i2c_reg_bridge #(
  parameter logic [6:0] I2C_ADDR    = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_read,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, TX, TX_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  // Synchronisers reset to the idle-bus level so reset release creates no edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, tx_q, tx_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
  logic       rw_q, rw_d, oe_q, oe_d, wr_q, wr_d, rd_q, rd_d, busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      tx_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
`ifdef I2C_AUTOINC_EN
    if (wr_q) addr_d = addr_q + 8'd1;
`endif
    case (state_q)
      ADDR: begin
        if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_s};
          cnt_d   = cnt_q + 4'd1;
        end else if (scl_fall && cnt_q == 4'd8) begin
          if (shift_q[7:1] == I2C_ADDR) begin
            oe_d    = 1'b1;
            busy_d  = 1'b1;
            rw_d    = shift_q[0];
            state_d = ADDR_ACK;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      ADDR_ACK: begin
        if (scl_fall) begin
          oe_d  = 1'b0;
          cnt_d = '0;
          if (rw_q) begin
            rd_d    = 1'b1;
            state_d = TX;
          end else begin
            state_d = PTR;
          end
        end
      end
      PTR: begin
        if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_s};
          cnt_d   = cnt_q + 4'd1;
        end else if (scl_fall && cnt_q == 4'd8) begin
          addr_d  = shift_q;
          oe_d    = 1'b1;
          state_d = PTR_ACK;
        end
      end
      PTR_ACK, WR_ACK: begin
        if (scl_fall) begin
          oe_d    = 1'b0;
          cnt_d   = '0;
          state_d = WR;
        end
      end
      WR: begin
        if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_s};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            wdata_d = {shift_q[6:0], sda_s};
            wr_d    = 1'b1;
          end
        end else if (scl_fall && cnt_q == 4'd8) begin
          oe_d    = 1'b1;
          state_d = WR_ACK;
        end
      end
      TX: begin
        // The cycle holding reg_read is the load slot for the next outgoing byte.
        if (rd_q) begin
          tx_d = reg_rdata;
          oe_d = ~reg_rdata[7];
        end else if (scl_rise) begin
          cnt_d = cnt_q + 4'd1;
        end else if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            oe_d    = 1'b0;
            state_d = TX_ACK;
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
            oe_d = ~tx_q[6];
          end
        end
      end
      TX_ACK: begin
        if (scl_rise && sda_s) begin
          state_d = WAIT_STOP;
        end else if (scl_fall) begin
          cnt_d   = '0;
          rd_d    = 1'b1;
          state_d = TX;
`ifdef I2C_AUTOINC_EN
          addr_d  = addr_q + 8'd1;
`endif
        end
      end
      default: ;
    endcase

    if (start_det) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
    end else if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
    end
  end

  assign sda_oe    = oe_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr    = wr_q;
  assign reg_read  = rd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// Directed bench for i2c_reg_bridge: bit-banged I2C master, open-drain SDA, strobe logger.
// Expected burst addresses follow I2C_AUTOINC_EN when the bench is built with it.
module tb_i2c_reg_bridge;

`ifdef I2C_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int Q = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, reg_wr, reg_read, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
  logic [7:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];

  always #5 clk = ~clk;

  assign sda_line  = sda_m & ~sda_oe;
  assign reg_rdata = reg_addr ^ 8'hA7;

  i2c_reg_bridge dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_read(reg_read),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  always @(negedge clk) begin
    if (reg_wr && wr_cnt < 64) begin
      wr_addr_log[wr_cnt] = reg_addr;
      wr_data_log[wr_cnt] = reg_wdata;
    end
    if (reg_wr) wr_cnt++;
    if (reg_read) rd_cnt++;
    if (reg_wr && reg_read) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl = 1'b1;   #Q;
    sda_m = 1'b0; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl = 1'b1;   #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; #Q;
      scl = 1'b1;   #(2*Q);
      scl = 1'b0;   #Q;
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_m = 1'b1; #Q;
    scl = 1'b1;   #Q;
    ack = ~sda_line; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic read_byte(input logic give_ack, output logic [7:0] d);
    d = '0;
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #Q; scl = 1'b1;
      #Q; d = {d[6:0], sda_line};
      #Q; scl = 1'b0;
      #Q;
    end
    sda_m = ~give_ack; #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0;
    sda_m = 1'b1; #Q;
  endtask

  logic       ack;
  logic [7:0] d;
  int         w0, r0;

  initial begin
    #23;
    check("rst_sda_oe", sda_oe, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_reg_wr", reg_wr, 0);
    check("rst_reg_read", reg_read, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1; #100;

    // single write
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'h84, ack); check("w1_addr_ack", ack, 1);
    check("w1_busy", busy, 1);
    write_byte(8'h20, ack); check("w1_ptr_ack", ack, 1);
    write_byte(8'h5A, ack); check("w1_data_ack", ack, 1);
    i2c_stop(); #100;
    check("w1_wr_count", wr_cnt - w0, 1);
    check("w1_wr_addr", wr_addr_log[w0], 8'h20);
    check("w1_wr_data", wr_data_log[w0], 8'h5A);
    check("w1_busy_after_stop", busy, 0);

    // pointer write, repeated start, single read with NACK
    w0 = wr_cnt; r0 = rd_cnt;
    i2c_start();
    write_byte(8'h84, ack); check("r1_addr_ack", ack, 1);
    write_byte(8'h00, ack); check("r1_ptr_ack", ack, 1);
    i2c_start();
    write_byte(8'h85, ack); check("r1_raddr_ack", ack, 1);
    read_byte(1'b0, d);     check("r1_data", d, 8'hA7);
    i2c_stop(); #100;
    check("r1_rd_count", rd_cnt - r0, 1);
    check("r1_wr_count", wr_cnt - w0, 0);

    // two-byte read with master ACK on the first
    r0 = rd_cnt;
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h03, ack);
    i2c_start();
    write_byte(8'h85, ack);
    read_byte(1'b1, d); check("r2_byte0", d, 8'hA4);
    read_byte(1'b0, d); check("r2_byte1", d, AUTOINC ? 8'hA3 : 8'hA4);
    i2c_stop(); #100;
    check("r2_rd_count", rd_cnt - r0, 2);

    // wrong address
    w0 = wr_cnt; r0 = rd_cnt;
    i2c_start();
    write_byte(8'h86, ack); check("na_ack", ack, 0);
    check("na_busy", busy, 0);
    write_byte(8'h11, ack); check("na_data_ack", ack, 0);
    i2c_stop(); #100;
    check("na_wr_count", wr_cnt - w0, 0);
    check("na_rd_count", rd_cnt - r0, 0);

    // burst write of three bytes
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h05, ack);
    write_byte(8'h11, ack); check("b_ack0", ack, 1);
    write_byte(8'h22, ack); check("b_ack1", ack, 1);
    write_byte(8'h33, ack); check("b_ack2", ack, 1);
    i2c_stop(); #100;
    check("b_wr_count", wr_cnt - w0, 3);
    check("b_addr0", wr_addr_log[w0],   8'h05);
    check("b_addr1", wr_addr_log[w0+1], AUTOINC ? 8'h06 : 8'h05);
    check("b_addr2", wr_addr_log[w0+2], AUTOINC ? 8'h07 : 8'h05);
    check("b_data2", wr_data_log[w0+2], 8'h33);

    // pointer wrap
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'hFF, ack);
    write_byte(8'hC3, ack);
    write_byte(8'h3C, ack);
    i2c_stop(); #100;
    check("wrap_wr_count", wr_cnt - w0, 2);
    check("wrap_addr0", wr_addr_log[w0],   8'hFF);
    check("wrap_addr1", wr_addr_log[w0+1], AUTOINC ? 8'h00 : 8'hFF);
    check("wrap_data1", wr_data_log[w0+1], 8'h3C);

    // STOP in the middle of a data byte
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h10, ack);
    send_bits(8'hF0, 4);
    i2c_stop(); #100;
    check("part_wr_count", wr_cnt - w0, 0);
    check("part_reg_addr", reg_addr, 8'h10);
    check("part_busy", busy, 0);

    // async reset while the target drives a read bit
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h01, ack);
    i2c_start();
    write_byte(8'h85, ack);
    sda_m = 1'b1;
    #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    check("rr_sda_oe_driving", sda_oe, 1);
    rst_n = 1'b0; #1;
    check("rr_sda_oe", sda_oe, 0);
    check("rr_busy", busy, 0);
    check("rr_reg_addr", reg_addr, 0);
    #30 rst_n = 1'b1; #50;
    write_byte(8'h84, ack); check("rr_idle_no_ack", ack, 0);
    i2c_stop(); #100;
    i2c_start();
    write_byte(8'h84, ack); check("rr_recover_ack", ack, 1);
    write_byte(8'h30, ack);
    i2c_stop(); #100;
    check("rr_recover_ptr", reg_addr, 8'h30);

    check("wr_rd_overlap", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
